// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
// AHB-Lite slave that terminates the bus and keeps its data in an internal
// word-organised SRAM. It supports byte, halfword and word transfers, a
// programmable number of wait states, and the two-cycle ERROR response.
//
// Optional feature: define AHB_SLV_WPROT_EN to make every in-range write at
// or above WPROT_BASE take the ERROR response and leave the SRAM untouched.
// Reads of that region still return OKAY. With the macro undefined,
// WPROT_BASE has no effect.
//
// Ports:
//   HCLK       in   clock, rising edge
//   HRSTN      in   synchronous active-low reset
//   HSEL       in   slave select
//   HREADY     in   bus ready, qualifies the address phase
//   HADDR      in   byte address [ADDR_W-1:0]
//   HTRANS     in   IDLE/BUSY/NONSEQ/SEQ
//   HWRITE     in   1 = write, 0 = read
//   HSIZE      in   byte/halfword/word
//   HWDATA     in   write data, valid in the data phase
//   HREADYOUT  out  transfer-complete indication
//   HRESP      out  0 = OKAY, 1 = ERROR
//   HRDATA     out  registered read data
module ahb_sram_slave #(
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH_WORDS = 1024,
  parameter int                WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] WPROT_BASE  = 16'h0F00
) (
  input  logic              HCLK,
  input  logic              HRSTN,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA
);

  localparam int              IDXW      = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] BYTES     = (ADDR_W + 1)'(DEPTH_WORDS * 4);
  localparam logic [3:0]      WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t            state_q, state_d;
  logic [3:0]        waitCnt_q, waitCnt_d;
  logic              dpValid_q, dpWrite_q, dpErr_q;
  logic [1:0]        dpLane_q;
  logic [2:0]        dpSize_q;
  logic [IDXW-1:0]   dpIdx_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept, errFlag, outOfRange, sizeBad, misalign, wprotHit;
  logic              commit;
  logic [IDXW-1:0]   addrIdx;
  logic [3:0]        strb;
  logic [31:0]       wrMask, rdWord;
  logic              unusedBits;

  assign unusedBits = HTRANS[0];
  assign addrIdx    = HADDR[IDXW+1:2];
  assign accept     = HSEL && HREADY && HTRANS[1] && HREADYOUT;

  // Address-phase checks; any one of them turns the transfer into an ERROR.
  always_comb begin
    outOfRange = {1'b0, HADDR} >= BYTES;
    sizeBad    = HSIZE > 3'b010;
    misalign   = ((HSIZE == 3'b001) && HADDR[0]) ||
                 ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
    errFlag    = outOfRange || sizeBad || misalign || wprotHit;
  end

`ifdef AHB_SLV_WPROT_EN
  assign wprotHit = HWRITE && (HADDR >= WPROT_BASE);
`else
  logic unusedWprot;
  assign wprotHit    = 1'b0;
  assign unusedWprot = ^WPROT_BASE;
`endif

  // Response outputs depend only on the state, so they are glitch-free with
  // respect to the bus inputs. WAIT releases HREADYOUT once the count is used up.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      ST_WAIT: HREADYOUT = (waitCnt_q == 4'd0);
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  // Next state. Each state first handles its own step. A new address phase
  // can only be accepted while HREADYOUT is high, and it then takes
  // precedence and chooses the path of the new data phase.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      ST_WAIT: begin
        if (waitCnt_q != 4'd0) waitCnt_d = waitCnt_q - 4'd1;
        else                   state_d   = ST_IDLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: ;
    endcase
    if (accept) begin
      if (errFlag) begin
        state_d = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d   = ST_WAIT;
        waitCnt_d = WAIT_LOAD;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRSTN) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Lane strobes come from the latched size and the low address bits.
  always_comb begin
    case (dpSize_q)
      3'b000:  strb = 4'b0001 << dpLane_q;
      3'b001:  strb = dpLane_q[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    wrMask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  end

  // A write is committed in the cycle its data phase completes with OKAY.
  // HRSTN gates the commit so that a reset drops a pending write.
  assign commit = dpValid_q && dpWrite_q && !dpErr_q && HREADYOUT && HRSTN;

  // The array is read during the address phase. If the write being committed
  // on the same edge targets the same word, its new lanes are merged in.
  always_comb begin
    rdWord = mem[addrIdx];
    if (commit && (dpIdx_q == addrIdx)) begin
      rdWord = (rdWord & ~wrMask) | (HWDATA & wrMask);
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) mem[dpIdx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // Data-phase bookkeeping only advances when the current phase completes.
  // Read data is captured when a good read is accepted and then held.
  always_ff @(posedge HCLK) begin
    if (!HRSTN) begin
      dpValid_q <= 1'b0;
      dpWrite_q <= 1'b0;
      dpErr_q   <= 1'b0;
      dpLane_q  <= 2'b00;
      dpSize_q  <= 3'b000;
      dpIdx_q   <= '0;
      rdata_q   <= 32'h0;
    end else begin
      if (HREADYOUT) begin
        dpValid_q <= accept;
        if (accept) begin
          dpWrite_q <= HWRITE;
          dpErr_q   <= errFlag;
          dpLane_q  <= HADDR[1:0];
          dpSize_q  <= HSIZE;
          dpIdx_q   <= addrIdx;
        end
      end
      if (accept && !errFlag && !HWRITE) rdata_q <= rdWord;
    end
  end

  assign HRDATA = rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave
// Directed bench for ahb_sram_slave. Instance dut0 runs with zero wait
// states and instance dut1 with three. Both share the bus signals, and the
// HSEL of each is driven according to 'target'. Each slave's HREADY is tied
// to its own HREADYOUT, as in a single-slave system.
module tb_ahb_sram_slave;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010, SZ_BAD = 3'b011;

  logic        HCLK = 1'b0;
  logic        HRSTN;
  logic        HSEL0, HSEL1;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [15:0] HADDR;
  logic [31:0] HWDATA;
  logic        rdy0, resp0, rdy1, resp1;
  logic [31:0] rdata0, rdata1;

  int checks = 0;
  int errors = 0;
  int target = 0;

  always #5 HCLK = ~HCLK;

  ahb_sram_slave #(.ADDR_W(16), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRSTN(HRSTN), .HSEL(HSEL0), .HREADY(rdy0), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
  );

  ahb_sram_slave #(.ADDR_W(16), .DEPTH_WORDS(1024), .WAIT_STATES(3)) dut1 (
    .HCLK(HCLK), .HRSTN(HRSTN), .HSEL(HSEL1), .HREADY(rdy1), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rdata1)
  );

  // Drives one bus cycle: the address phase fields plus the HWDATA of the
  // data phase that is in flight. Returns 1 time unit after the rising edge.
  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                               input logic [2:0] size, input logic [15:0] addr,
                               input logic [31:0] wdata);
    HSEL0  = sel && (target == 0);
    HSEL1  = sel && (target == 1);
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = size;
    HADDR  = addr;
    HWDATA = wdata;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRSTN = 1'b0;
    applyStimulus(0, T_IDLE, 0, SZ_W, 16'h0, 32'h0);
    applyStimulus(0, T_IDLE, 0, SZ_W, 16'h0, 32'h0);
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", rdy0); end
    checks++; if (resp0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp: got %b want 0", resp0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 00000000", rdata0); end
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_ws: got %b want 1", rdy1); end
    HRSTN = 1'b1;
    applyStimulus(0, T_IDLE, 0, SZ_W, 16'h0, 32'h0);
  endtask

  task automatic test_word_rw();
    int stalls = 0;
    target = 0;
    applyStimulus(1, T_NSEQ, 1, SZ_W, 16'h0010, 32'h0);
    if (rdy0 !== 1'b1) stalls++;
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0000, 32'hDEADBEEF);
    if (rdy0 !== 1'b1) stalls++;
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0010, 32'h0);
    if (rdy0 !== 1'b1) stalls++;
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL word_read: got %h want DEADBEEF", rdata0); end
    checks++; if (resp0 !== 1'b0) begin errors++; $display("[TB] FAIL word_resp: got %b want 0", resp0); end
    checks++; if (stalls != 0) begin errors++; $display("[TB] FAIL word_nowait: got %0d stall cycles want 0", stalls); end
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0, 32'h0);
  endtask

  task automatic test_byte_lanes();
    target = 0;
    applyStimulus(1, T_NSEQ, 1, SZ_W, 16'h0020, 32'h0);
    applyStimulus(1, T_NSEQ, 1, SZ_B, 16'h0022, 32'h00000000);
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0000, 32'hFFA5FFFF);
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0020, 32'h0);
    checks++; if (rdata0 !== 32'h00A50000) begin errors++; $display("[TB] FAIL byte_lane2: got %h want 00A50000", rdata0); end
    applyStimulus(1, T_NSEQ, 1, SZ_H, 16'h0020, 32'h0);
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0000, 32'h1234BEEF);
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0020, 32'h0);
    checks++; if (rdata0 !== 32'h00A5BEEF) begin errors++; $display("[TB] FAIL half_lo: got %h want 00A5BEEF", rdata0); end
    applyStimulus(1, T_NSEQ, 1, SZ_H, 16'h0022, 32'h0);
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0000, 32'h7E57AAAA);
    applyStimulus(1, T_NSEQ, 0, SZ_B, 16'h0023, 32'h0);
    checks++; if (rdata0 !== 32'h7E57BEEF) begin errors++; $display("[TB] FAIL half_hi: got %h want 7E57BEEF", rdata0); end
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0, 32'h0);
  endtask

  task automatic test_forwarding();
    target = 0;
    applyStimulus(1, T_NSEQ, 1, SZ_W, 16'h0040, 32'h0);
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0040, 32'h12345678);
    checks++; if (rdata0 !== 32'h12345678) begin errors++; $display("[TB] FAIL fwd_word: got %h want 12345678", rdata0); end
    applyStimulus(1, T_NSEQ, 1, SZ_B, 16'h0041, 32'h0);
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0040, 32'hAAAA99AA);
    checks++; if (rdata0 !== 32'h12349978) begin errors++; $display("[TB] FAIL fwd_byte: got %h want 12349978", rdata0); end
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    target = 0;
    applyStimulus(1, T_NSEQ, 1, SZ_W, 16'h0050, 32'h0);
    if (rdy0 !== 1'b1) stalls++;
    applyStimulus(1, T_SEQ, 1, SZ_W, 16'h0054, 32'h0A0A0A0A);
    if (rdy0 !== 1'b1) stalls++;
    applyStimulus(1, T_SEQ, 1, SZ_W, 16'h0058, 32'h0B0B0B0B);
    if (rdy0 !== 1'b1) stalls++;
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0050, 32'h0C0C0C0C);
    checks++; if (rdata0 !== 32'h0A0A0A0A) begin errors++; $display("[TB] FAIL b2b_rd0: got %h want 0A0A0A0A", rdata0); end
    applyStimulus(1, T_SEQ, 0, SZ_W, 16'h0054, 32'h0);
    checks++; if (rdata0 !== 32'h0B0B0B0B) begin errors++; $display("[TB] FAIL b2b_rd1: got %h want 0B0B0B0B", rdata0); end
    applyStimulus(1, T_SEQ, 0, SZ_W, 16'h0058, 32'h0);
    checks++; if (rdata0 !== 32'h0C0C0C0C) begin errors++; $display("[TB] FAIL b2b_rd2: got %h want 0C0C0C0C", rdata0); end
    checks++; if (stalls != 0) begin errors++; $display("[TB] FAIL b2b_stall: got %0d want 0", stalls); end
    applyStimulus(1, T_BUSY, 0, SZ_W, 16'h0060, 32'h0);
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0, 32'h0);
    checks++; if ((rdy0 !== 1'b1) || (resp0 !== 1'b0)) begin errors++; $display("[TB] FAIL busy_okay: got rdy=%b resp=%b want 1/0", rdy0, resp0); end
    // Deselecting during the data phase must not abort the write.
    applyStimulus(1, T_NSEQ, 1, SZ_W, 16'h0070, 32'h0);
    applyStimulus(0, T_IDLE, 0, SZ_W, 16'h0000, 32'h77777777);
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0070, 32'h0);
    checks++; if (rdata0 !== 32'h77777777) begin errors++; $display("[TB] FAIL hsel_drop: got %h want 77777777", rdata0); end
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0, 32'h0);
  endtask

  task automatic test_error();
    target = 0;
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0002, 32'h0);
    checks++; if ((rdy0 !== 1'b0) || (resp0 !== 1'b1)) begin errors++; $display("[TB] FAIL misalign_err1: got rdy=%b resp=%b want 0/1", rdy0, resp0); end
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0000, 32'h0);
    checks++; if ((rdy0 !== 1'b1) || (resp0 !== 1'b1)) begin errors++; $display("[TB] FAIL misalign_err2: got rdy=%b resp=%b want 1/1", rdy0, resp0); end
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h1000, 32'h0);
    checks++; if ((rdy0 !== 1'b0) || (resp0 !== 1'b1)) begin errors++; $display("[TB] FAIL range_err1: got rdy=%b resp=%b want 0/1", rdy0, resp0); end
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0000, 32'h0);
    checks++; if ((rdy0 !== 1'b1) || (resp0 !== 1'b1)) begin errors++; $display("[TB] FAIL range_err2: got rdy=%b resp=%b want 1/1", rdy0, resp0); end
    // A read presented during ERR2 is taken as a normal transfer.
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0010, 32'h0);
    checks++; if ((rdy0 !== 1'b1) || (resp0 !== 1'b0) || (rdata0 !== 32'hDEADBEEF))
      begin errors++; $display("[TB] FAIL err2_accept: got rdy=%b resp=%b data=%h want 1/0/DEADBEEF", rdy0, resp0, rdata0); end
    // Failed writes (misaligned, bad size, out of range) must leave the SRAM alone.
    applyStimulus(1, T_NSEQ, 1, SZ_W, 16'h0012, 32'h0);
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0000, 32'hBAD0BAD0);
    applyStimulus(1, T_NSEQ, 1, SZ_BAD, 16'h0010, 32'hBAD0BAD0);
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0000, 32'hBAD1BAD1);
    applyStimulus(1, T_NSEQ, 1, SZ_W, 16'h1010, 32'hBAD1BAD1);
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0000, 32'hBAD2BAD2);
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0010, 32'hBAD2BAD2);
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL err_nowrite: got %h want DEADBEEF", rdata0); end
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0, 32'h0);
  endtask

  task automatic test_wait_states();
    int waits;
    int guard;
    target = 1;
    applyStimulus(1, T_NSEQ, 1, SZ_W, 16'h0004, 32'h0);
    waits = (rdy1 === 1'b0) ? 1 : 0;
    guard = 0;
    while ((rdy1 !== 1'b1) && (guard < 20)) begin
      applyStimulus(0, T_IDLE, 0, SZ_W, 16'h0000, 32'hCAFEF00D);
      if (rdy1 === 1'b0) waits++;
      guard++;
    end
    checks++; if (waits != 3) begin errors++; $display("[TB] FAIL ws_write_waits: got %0d want 3", waits); end
    checks++; if (resp1 !== 1'b0) begin errors++; $display("[TB] FAIL ws_write_resp: got %b want 0", resp1); end
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0004, 32'hCAFEF00D);
    waits = (rdy1 === 1'b0) ? 1 : 0;
    guard = 0;
    while ((rdy1 !== 1'b1) && (guard < 20)) begin
      applyStimulus(0, T_IDLE, 0, SZ_W, 16'h0000, 32'h0);
      if (rdy1 === 1'b0) waits++;
      guard++;
    end
    checks++; if (waits != 3) begin errors++; $display("[TB] FAIL ws_read_waits: got %0d want 3", waits); end
    checks++; if (rdata1 !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL ws_read_data: got %h want CAFEF00D", rdata1); end
    applyStimulus(0, T_IDLE, 0, SZ_W, 16'h0, 32'h0);
  endtask

  task automatic test_wprot();
    target = 0;
`ifdef AHB_SLV_WPROT_EN
    applyStimulus(1, T_NSEQ, 1, SZ_W, 16'h0F00, 32'h0);
    checks++; if ((rdy0 !== 1'b0) || (resp0 !== 1'b1)) begin errors++; $display("[TB] FAIL wprot_err1: got rdy=%b resp=%b want 0/1", rdy0, resp0); end
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0000, 32'hA5A55A5A);
    checks++; if ((rdy0 !== 1'b1) || (resp0 !== 1'b1)) begin errors++; $display("[TB] FAIL wprot_err2: got rdy=%b resp=%b want 1/1", rdy0, resp0); end
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0F00, 32'hA5A55A5A);
    checks++; if ((rdy0 !== 1'b1) || (resp0 !== 1'b0)) begin errors++; $display("[TB] FAIL wprot_read_ok: got rdy=%b resp=%b want 1/0", rdy0, resp0); end
    checks++; if (rdata0 === 32'hA5A55A5A) begin errors++; $display("[TB] FAIL wprot_unchanged: got %h want old contents", rdata0); end
`else
    applyStimulus(1, T_NSEQ, 1, SZ_W, 16'h0F00, 32'h0);
    checks++; if ((rdy0 !== 1'b1) || (resp0 !== 1'b0)) begin errors++; $display("[TB] FAIL noprot_write: got rdy=%b resp=%b want 1/0", rdy0, resp0); end
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0F00, 32'hA5A55A5A);
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0000, 32'h0);
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0F00, 32'h0);
    checks++; if (rdata0 !== 32'hA5A55A5A) begin errors++; $display("[TB] FAIL noprot_read: got %h want A5A55A5A", rdata0); end
`endif
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0, 32'h0);
  endtask

  task automatic test_reset_midway();
    target = 0;
    applyStimulus(1, T_NSEQ, 1, SZ_W, 16'h0060, 32'h0);
    applyStimulus(1, T_NSEQ, 1, SZ_W, 16'h0060, 32'h11112222);
    HRSTN = 1'b0;
    applyStimulus(0, T_IDLE, 0, SZ_W, 16'h0000, 32'h99999999);
    checks++; if ((rdy0 !== 1'b1) || (resp0 !== 1'b0) || (rdata0 !== 32'h0))
      begin errors++; $display("[TB] FAIL midrst_outputs: got rdy=%b resp=%b data=%h want 1/0/00000000", rdy0, resp0, rdata0); end
    HRSTN = 1'b1;
    applyStimulus(1, T_NSEQ, 0, SZ_W, 16'h0060, 32'h0);
    checks++; if (rdata0 !== 32'h11112222) begin errors++; $display("[TB] FAIL midrst_drop: got %h want 11112222", rdata0); end
    applyStimulus(1, T_IDLE, 0, SZ_W, 16'h0, 32'h0);
    target = 1;
    applyStimulus(1, T_NSEQ, 1, SZ_W, 16'h0008, 32'h0);
    HRSTN = 1'b0;
    applyStimulus(0, T_IDLE, 0, SZ_W, 16'h0000, 32'h0);
    checks++; if ((rdy1 !== 1'b1) || (resp1 !== 1'b0)) begin errors++; $display("[TB] FAIL midrst_wait: got rdy=%b resp=%b want 1/0", rdy1, resp1); end
    HRSTN = 1'b1;
    applyStimulus(0, T_IDLE, 0, SZ_W, 16'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    HRSTN  = 1'b0;
    HSEL0  = 1'b0;
    HSEL1  = 1'b0;
    HTRANS = T_IDLE;
    HWRITE = 1'b0;
    HSIZE  = SZ_W;
    HADDR  = 16'h0;
    HWDATA = 32'h0;
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_forwarding();
    test_back_to_back();
    test_error();
    test_wait_states();
    test_wprot();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave that terminates the ahb_intf bus: decodes address/data phases, returns HREADYOUT/HRESP/HRDATA, stores data in an internal word-organised SRAM array.
- Sits directly downstream of the bus interface; the testbench master drives it through ahb_intf.
- Supports byte/halfword/word transfers, programmable wait states and two-cycle ERROR responses.

Parameters:
- ADDR_W, 16, HADDR width.
- DEPTH_WORDS, 1024, number of 32-bit words; valid byte range 0 .. DEPTH_WORDS*4-1.
- WAIT_STATES, 0, wait cycles (HREADYOUT=0) inserted before completing each OKAY data phase; range 0..15.
- WPROT_BASE, 16'h0F00, first write-protected byte address; used only with the optional feature.

Ports:
- HCLK  input  1  clock, rising edge.
- HRSTN  input  1  synchronous active-low reset.
- HSEL  input  1  slave select.
- HREADY  input  1  bus ready; qualifies the address phase.
- HADDR  input  ADDR_W  byte address.
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  input  1  1=write, 0=read.
- HSIZE  input  3  000 byte, 001 halfword, 010 word.
- HWDATA  input  32  write data, valid in the data phase.
- HREADYOUT  output  1  transfer-complete indication.
- HRESP  output  1  0 OKAY, 1 ERROR.
- HRDATA  output  32  read data, valid when HREADYOUT=1 and HRESP=0 in a read data phase.

Behaviour:
- One clock (HCLK); reset is synchronous and active-low (HRSTN), sampled on the rising HCLK edge.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, pending-write register invalid. SRAM contents are not reset.
- Address phase accepted when HSEL && HREADY && HTRANS[1]. The slave registers HADDR, HWRITE and HSIZE, plus the error flag.
- IDLE or BUSY with HSEL=1: no transfer; the next data phase returns OKAY with zero wait.
- Error conditions:
  - Address ≥ DEPTH_WORDS*4.
  - HSIZE > 010.
  - Misalignment: halfword with HADDR[0]=1, or word with HADDR[1:0]≠00.
- FSM states IDLE, WAIT, ERR1, ERR2:
  - IDLE → WAIT: accepted OK transfer and WAIT_STATES>0. The counter loads WAIT_STATES; HREADYOUT=0 while the counter is nonzero. At 0 → IDLE with HREADYOUT=1, HRESP=0.
  - IDLE, accepted OK transfer and WAIT_STATES=0: data phase completes in one cycle (HREADYOUT=1).
  - Accepted error transfer → ERR1 (HREADYOUT=0, HRESP=1) → ERR2 (HREADYOUT=1, HRESP=1) → IDLE. Error transfers never modify the SRAM. Any address phase presented during ERR2 is accepted normally.
- Address phases are only accepted when HREADYOUT=1 (that is, in IDLE or the final cycle of WAIT/ERR2).
- Write commit:
  - Byte strobes come from HSIZE and the latched address[1:0]: byte → 1 lane; halfword → lanes {1:0} or {3:2}; word → all 4.
  - HWDATA lanes are written in the cycle the data phase completes (HREADYOUT=1, HRESP=0).
- Read:
  - The array is read at the address phase; HRDATA is registered and held stable until the next completed read.
  - The full 32-bit word is returned regardless of HSIZE.
- Read-after-write hazard: when a read's address phase overlaps the data phase of a write to the same word, HRDATA must return the merged (new) bytes via forwarding.
- Back-to-back pipelined NONSEQ/SEQ transfers run at full rate when WAIT_STATES=0.
- HSEL=0 during a data phase that is in progress does not abort it.
- Reset asserted mid-transfer:
  - Next cycle outputs take reset values.
  - A pending write is dropped without committing.

Optional Feature:
- Macro AHB_SLV_WPROT_EN.
- Defined: any write with latched address ≥ WPROT_BASE (and in range) takes the two-cycle ERROR response; the SRAM is unchanged. Reads there still return OKAY.
- Undefined: WPROT_BASE is ignored and all in-range writes succeed.

Test Plan:
- Reset with HRSTN=0 for 2 cycles → HREADYOUT=1, HRESP=0, HRDATA=32'h0.
- Word write 32'hDEADBEEF @0x0010, then word read @0x0010, WAIT_STATES=0 → read data phase HRDATA=32'hDEADBEEF, with no cycle where HREADYOUT=0.
- Word write 32'h00000000 @0x0020, then byte write 8'hA5 on lane 2 @0x0022 → read @0x0020 returns 32'h00A50000.
- Pipelined write 32'h12345678 @0x0040 immediately followed by read @0x0040 → HRDATA=32'h12345678 via forwarding.
- Word read @0x0002 (misaligned) and read @0x1000 (DEPTH_WORDS=1024) → each gives HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; SRAM unchanged.
- WAIT_STATES=3, word write @0x0004 → exactly 3 cycles of HREADYOUT=0, then 1 OKAY cycle. With AHB_SLV_WPROT_EN, write @0x0F00 → ERROR, and a read back returns the old value.
